// File: rtl/alu_pkg.sv
// Shared ALU definitions: shift opcodes, the request bundle carried through
// the issue register, and a bit-reverse helper for the left-shift ops.
package alu_pkg;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam int REQ_W = 14;

  typedef struct packed {
    logic [7:0] data;
    logic [2:0] amt;
    logic [1:0] op;
    logic       id;
  } req_t;

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = x[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift8_core.sv
// Combinational 8-bit shifter: a 4/2/1 right-shift mux network whose fill is
// zero for logical shifts and the wrapped-out bits for rotates.
module shift8_core
  import alu_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic [2:0] amt_i,
  input  logic [1:0] op_i,
  output logic [7:0] result_o
);

  logic       left;
  logic       rotate;
  logic [7:0] lvl0;
  logic [7:0] lvl1;
  logic [7:0] lvl2;
  logic [7:0] lvl3;

  // Left ops run through the same right-shift network on the bit-reversed word.
  always_comb begin
    left     = (op_i == OP_SLL) || (op_i == OP_ROL);
    rotate   = (op_i == OP_ROR) || (op_i == OP_ROL);
    lvl0     = left ? rev8(data_i) : data_i;
    lvl1     = amt_i[2] ? {(rotate ? lvl0[3:0] : 4'h0), lvl0[7:4]} : lvl0;
    lvl2     = amt_i[1] ? {(rotate ? lvl1[1:0] : 2'h0), lvl1[7:2]} : lvl1;
    lvl3     = amt_i[0] ? {(rotate ? lvl2[0] : 1'b0), lvl2[7:1]} : lvl2;
    result_o = left ? rev8(lvl3) : lvl3;
  end

endmodule

// File: rtl/shift_arbiter_8bit.sv
// Two-requester arbiter feeding a two-stage shift pipeline (issue register,
// shift core, response register) with valid/ready on both sides.
module shift_arbiter_8bit
  import alu_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_data,
  input  logic [2:0] req0_amt,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_data,
  input  logic [2:0] req1_amt,
  input  logic [1:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_id
);

  req_t       s1_q, s1_d;
  logic       s1_valid_q, s1_valid_d;
  logic       s2_valid_q, s2_valid_d;
  logic [7:0] s2_data_q, s2_data_d;
  logic       s2_id_q, s2_id_d;
  logic       last_grant_q, last_grant_d;

  logic       s2_adv;
  logic       s1_can_accept;
  logic       grant0;
  logic       grant1;
  logic [7:0] core_result;

  shift8_core u_core (
    .data_i   (s1_q.data),
    .amt_i    (s1_q.amt),
    .op_i     (s1_q.op),
    .result_o (core_result)
  );

  // Ready is combinational through S2 so a draining consumer frees S1 in the same cycle.
  always_comb begin
    s2_adv        = !s2_valid_q || rsp_ready;
    s1_can_accept = !s1_valid_q || s2_adv;
    grant0        = req0_valid && (!req1_valid || !RR_EN || last_grant_q);
    grant1        = req1_valid && !grant0;
    req0_ready    = grant0 && s1_can_accept && !rst;
    req1_ready    = grant1 && s1_can_accept && !rst;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    s1_d         = s1_q;
    s1_valid_d   = s1_valid_q;
    s2_valid_d   = s2_valid_q;
    s2_data_d    = s2_data_q;
    s2_id_d      = s2_id_q;

    if (req0_ready) begin
      last_grant_d = 1'b0;
      s1_valid_d   = 1'b1;
      s1_d         = '{data: req0_data, amt: req0_amt, op: req0_op, id: 1'b0};
    end else if (req1_ready) begin
      last_grant_d = 1'b1;
      s1_valid_d   = 1'b1;
      s1_d         = '{data: req1_data, amt: req1_amt, op: req1_op, id: 1'b1};
    end else if (s2_adv) begin
      s1_valid_d   = 1'b0;
    end

    // Payload only moves with a real entry so an idle S2 keeps its last result.
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = core_result;
        s2_id_d   = s1_q.id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
      s1_q         <= '0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_data_q    <= 8'h00;
      s2_id_q      <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      s1_q         <= s1_d;
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      s2_data_q    <= s2_data_d;
      s2_id_q      <= s2_id_d;
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_data  = s2_data_q;
  assign rsp_id    = s2_id_q;

endmodule

// File: tb/tb_shift_arbiter_8bit.sv
// Directed bench for shift_arbiter_8bit: a round-robin instance is checked
// throughout, and a fixed-priority twin shares its inputs for the grant test.
module tb_shift_arbiter_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_data, req1_data;
  logic [2:0] req0_amt, req1_amt;
  logic [1:0] req0_op, req1_op;
  logic       rsp_ready;

  logic       req0_ready_rr, req1_ready_rr, rsp_valid_rr, rsp_id_rr;
  logic [7:0] rsp_data_rr;
  logic       req0_ready_fp, req1_ready_fp, rsp_valid_fp, rsp_id_fp;
  logic [7:0] rsp_data_fp;

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] rq_rr[$];
  bit         gq_rr[$];
  bit         gq_fp[$];

  always #5 clk = ~clk;

  shift_arbiter_8bit #(.RR_EN(1'b1)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready_rr), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready_rr), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_op(req1_op),
    .rsp_valid(rsp_valid_rr), .rsp_ready(rsp_ready), .rsp_data(rsp_data_rr),
    .rsp_id(rsp_id_rr)
  );

  shift_arbiter_8bit #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready_fp), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready_fp), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_op(req1_op),
    .rsp_valid(rsp_valid_fp), .rsp_ready(rsp_ready), .rsp_data(rsp_data_fp),
    .rsp_id(rsp_id_fp)
  );

  // Record grants and delivered responses on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid_rr && rsp_ready) rq_rr.push_back({rsp_id_rr, rsp_data_rr});
      if (req0_valid && req0_ready_rr) gq_rr.push_back(1'b0);
      else if (req1_valid && req1_ready_rr) gq_rr.push_back(1'b1);
      if (req0_valid && req0_ready_fp) gq_fp.push_back(1'b0);
      else if (req1_valid && req1_ready_fp) gq_fp.push_back(1'b1);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input bit who, input logic [7:0] d, input logic [2:0] a,
                               input logic [1:0] o);
    bit got = 1'b0;
    if (!who) begin
      req0_data = d; req0_amt = a; req0_op = o; req0_valid = 1'b1;
    end else begin
      req1_data = d; req1_amt = a; req1_op = o; req1_valid = 1'b1;
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (who ? req1_ready_rr : req0_ready_rr) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) checkOutput("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (!who) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_b2b [3];
    logic [1:0] pt_ops [4];
    bit acc;
    int n;

    exp_b2b = '{8'hA0, 8'h96, 8'hA5};
    pt_ops  = '{2'b00, 2'b01, 2'b10, 2'b11};

    rst = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h00; req0_amt = 3'd0; req0_op = 2'b00;
    req1_valid = 1'b1; req1_data = 8'h00; req1_amt = 3'd0; req1_op = 2'b00;
    rsp_ready = 1'b1;

    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req0_ready", req0_ready_rr, 0);
    checkOutput("rst_req1_ready", req1_ready_rr, 0);
    checkOutput("rst_rsp_valid", rsp_valid_rr, 0);
    checkOutput("rst_rsp_data", rsp_data_rr, 8'h00);
    checkOutput("rst_rsp_id", rsp_id_rr, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
    idleCycles(1);

    $display("[TB] SRL with two-cycle latency");
    applyStimulus(1'b0, 8'hB4, 3'd3, 2'b00);
    @(negedge clk);
    checkOutput("srl_not_early", rsp_valid_rr, 0);
    @(negedge clk);
    checkOutput("srl_valid", rsp_valid_rr, 1);
    checkOutput("srl_data", rsp_data_rr, 8'h16);
    checkOutput("srl_id", rsp_id_rr, 0);
    idleCycles(2);

    $display("[TB] SLL/ROR/ROL back-to-back on req1");
    req1_valid = 1'b1; req1_data = 8'hB4; req1_amt = 3'd3; req1_op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 3) checkOutput("b2b_ready", req1_ready_rr, 1);
      if (i >= 2) begin
        checkOutput("b2b_valid", rsp_valid_rr, 1);
        checkOutput("b2b_data", rsp_data_rr, exp_b2b[i-2]);
        checkOutput("b2b_id", rsp_id_rr, 1);
      end
      @(posedge clk); #1;
      if (i == 0) req1_op = 2'b10;
      if (i == 1) req1_op = 2'b11;
      if (i == 2) req1_valid = 1'b0;
    end
    idleCycles(2);

    $display("[TB] round-robin vs fixed priority");
    applyReset();
    gq_rr.delete(); gq_fp.delete(); rq_rr.delete();
    req0_data = 8'h11; req0_amt = 3'd0; req0_op = 2'b00;
    req1_data = 8'h22; req1_amt = 3'd0; req1_op = 2'b00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (gq_rr.size() >= 6) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    idleCycles(4);
    checkOutput("rr_grant_count", gq_rr.size(), 6);
    checkOutput("fp_grant_count", gq_fp.size(), 6);
    for (int i = 0; i < 6; i++) begin
      checkOutput("rr_grant", (i < gq_rr.size()) ? gq_rr[i] : 1'bx, i % 2);
      checkOutput("fp_grant", (i < gq_fp.size()) ? gq_fp[i] : 1'bx, 0);
    end
    checkOutput("rr_rsp_count", rq_rr.size(), 6);
    for (int i = 0; i < 6 && i < rq_rr.size(); i++) begin
      checkOutput("rr_rsp", rq_rr[i], (i % 2) ? 9'h122 : 9'h011);
    end

    $display("[TB] backpressure");
    rq_rr.delete();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h01; req0_amt = 3'd0; req0_op = 2'b00;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      acc = req0_ready_rr;
      if (c >= 2) begin
        checkOutput("bp_hold_valid", rsp_valid_rr, 1);
        checkOutput("bp_hold_data", rsp_data_rr, 8'h01);
      end
      @(posedge clk); #1;
      if (acc) begin
        n++;
        req0_data = 8'(n + 1);
      end
    end
    checkOutput("bp_accepts", n, 2);
    @(negedge clk);
    checkOutput("bp_ready_low", req0_ready_rr, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    #1;
    checkOutput("bp_ready_return", req0_ready_rr, 1);
    for (int k = 0; k < 20 && n < 5; k++) begin
      @(negedge clk);
      acc = req0_ready_rr;
      @(posedge clk); #1;
      if (acc) begin
        n++;
        req0_data = 8'(n + 1);
      end
    end
    req0_valid = 1'b0;
    idleCycles(4);
    checkOutput("bp_drain_count", rq_rr.size(), 5);
    for (int i = 0; i < 5 && i < rq_rr.size(); i++) begin
      checkOutput("bp_drain", rq_rr[i], 9'(i + 1));
    end

    $display("[TB] amt=0 pass-through");
    rq_rr.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h5A, 3'd0, pt_ops[i]);
    idleCycles(4);
    checkOutput("pt_count", rq_rr.size(), 4);
    for (int i = 0; i < 4 && i < rq_rr.size(); i++) begin
      checkOutput("pt_data", rq_rr[i], 9'h05A);
    end

    $display("[TB] reset mid-operation");
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 8'hC3, 3'd1, 2'b00);
    applyStimulus(1'b0, 8'h3C, 3'd1, 2'b01);
    @(negedge clk);
    checkOutput("mid_full", rsp_valid_rr, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_rsp_cleared", rsp_valid_rr, 0);
    @(posedge clk); #1;
    rq_rr.delete(); gq_rr.delete();
    rsp_ready = 1'b1;
    idleCycles(4);
    checkOutput("mid_no_stale", rq_rr.size(), 0);
    req0_data = 8'h01; req0_amt = 3'd0; req0_op = 2'b00;
    req1_data = 8'h02; req1_amt = 3'd0; req1_op = 2'b00;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (gq_rr.size() >= 1) break;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checkOutput("mid_conflict_seen", gq_rr.size() >= 1, 1);
    checkOutput("mid_conflict_grant", (gq_rr.size() >= 1) ? gq_rr[0] : 1'bx, 0);
    idleCycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
